// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  C_FC_NONE     = 2'd0;
    localparam logic [1:0]  C_FC_MISALIGN = 2'd1;
    localparam logic [1:0]  C_FC_TIMEOUT  = 2'd2;

    localparam logic [31:0] C_RESET_PC_DEFAULT    = 32'h0000_3000;
    localparam int          C_ACK_TIMEOUT_DEFAULT = 255;

    localparam int IMM16_W  = 16;
    localparam int TARGET_W = 26;
    localparam int CTR_W    = 8;

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : fetch_timeout_ctr
// Brief    : Counts REQ cycles without ack; tc flags the last allowed cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_timeout_ctr
    import instr_fetch_pkg::*;
#(
    parameter int ACK_TIMEOUT = C_ACK_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // tc marks the ACK_TIMEOUT-th waiting cycle, so the FSM can fault on that edge.
    localparam logic [CTR_W-1:0] C_TC_VALUE = CTR_W'(ACK_TIMEOUT - 1);

    logic [CTR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == C_TC_VALUE);

endmodule : fetch_timeout_ctr
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Holds the PC, fetches words over req/ack, raises sticky faults.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = C_RESET_PC_DEFAULT,
    parameter int          ACK_TIMEOUT = C_ACK_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         NextPC,
    input  logic                stall,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         PC,
    output logic [31:0]         Instr,
    output logic [IMM16_W-1:0]  imm16,
    output logic [TARGET_W-1:0] target,
    output logic                instr_valid,
    output logic                fault,
    output logic [1:0]          fault_code
);

    fetch_state_t r_state;
    logic         w_ctr_clr;
    logic         w_ctr_en;
    logic         w_ctr_tc;

    assign w_ctr_clr = (r_state != ST_REQ) || imem_ack;
    assign w_ctr_en  = (r_state == ST_REQ) && !imem_ack;

    fetch_timeout_ctr #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_ctr_clr),
        .en    (w_ctr_en),
        .tc    (w_ctr_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RESET;
            PC          <= RESET_PC;
            Instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= C_FC_NONE;
        end else begin
            unique case (r_state)
                ST_RESET: begin
                    r_state  <= ST_REQ;
                    imem_req <= 1'b1;
                end
                ST_REQ: begin
                    // An ack on the terminal cycle still wins over the timeout.
                    if (imem_ack) begin
                        Instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        r_state     <= ST_HOLD;
                    end else if (w_ctr_tc) begin
                        fault_code <= C_FC_TIMEOUT;
                        fault      <= 1'b1;
                        imem_req   <= 1'b0;
                        r_state    <= ST_FAULT;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if (NextPC[1:0] != 2'b00) begin
                            fault_code  <= C_FC_MISALIGN;
                            fault       <= 1'b1;
                            instr_valid <= 1'b0;
                            r_state     <= ST_FAULT;
                        end else begin
                            PC          <= NextPC;
                            instr_valid <= 1'b0;
                            imem_req    <= 1'b1;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_RESET;
                end
            endcase
        end
    end

    assign imem_addr = PC;
    assign imm16     = Instr[IMM16_W-1:0];
    assign target    = Instr[TARGET_W-1:0];

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch with ACK_TIMEOUT = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] C_RST_PC  = 32'h0000_3000;
    localparam int          C_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] NextPC;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic [15:0] imm16;
    logic [25:0] target;
    logic        instr_valid;
    logic        fault;
    logic [1:0]  fault_code;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    instr_fetch #(
        .RESET_PC    (C_RST_PC),
        .ACK_TIMEOUT (C_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .NextPC      (NextPC),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .Instr       (Instr),
        .imm16       (imm16),
        .target      (target),
        .instr_valid (instr_valid),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          stall_n;
        logic [31:0] next_pc;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, PC, C_RST_PC);
        check({tag, "_instr"}, Instr, 32'h0);
        check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
        check({tag, "_req"}, {31'h0, imem_req}, 32'h0);
        check({tag, "_fault"}, {31'h0, fault}, 32'h0);
        check({tag, "_fcode"}, {30'h0, fault_code}, 32'h0);
    endtask

    // Holds reset two cycles, then releases; returns in the first REQ cycle.
    task automatic do_reset(input string tag);
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        stall    = 1'b0;
        step();
        step();
        check_reset_state(tag);
        rst_n = 1'b1;
        step();
        check({tag, "_req_rise"}, {31'h0, imem_req}, 32'h1);
        check({tag, "_addr"}, imem_addr, C_RST_PC);
    endtask

    // Called in a REQ cycle; waits lat cycles (stall set, which must not matter), then acks.
    task automatic fetch(input logic [31:0] rdata, input int lat, input logic [31:0] exp_addr);
        logic [31:0] e;
        for (int i = 0; i < lat; i++) begin
            stall = 1'b1;
            step();
            check("wait_req", {31'h0, imem_req}, 32'h1);
            check("wait_addr", imem_addr, exp_addr);
            check("wait_nofault", {31'h0, fault}, 32'h0);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        exp_q.push_back(rdata);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("hold_valid", {31'h0, instr_valid}, 32'h1);
        check("hold_req", {31'h0, imem_req}, 32'h0);
        if (instr_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_instr", Instr, e);
            check("sb_imm16", {16'h0, imm16}, {16'h0, e[15:0]});
            check("sb_target", {6'h0, target}, {6'h0, e[25:0]});
        end
    endtask

    // Called in HOLD; stalls with wandering NextPC, then advances to next_pc.
    task automatic advance(input int stall_n, input logic [31:0] next_pc, input logic [31:0] cur_pc,
                           input logic [31:0] cur_instr);
        for (int i = 0; i < stall_n; i++) begin
            stall  = 1'b1;
            NextPC = $urandom();
            step();
            check("stall_pc", PC, cur_pc);
            check("stall_instr", Instr, cur_instr);
            check("stall_valid", {31'h0, instr_valid}, 32'h1);
            check("stall_req", {31'h0, imem_req}, 32'h0);
            check("stall_fault", {31'h0, fault}, 32'h0);
        end
        stall  = 1'b0;
        NextPC = next_pc;
        step();
        check("adv_pc", PC, next_pc);
        check("adv_addr", imem_addr, next_pc);
        check("adv_req", {31'h0, imem_req}, 32'h1);
        check("adv_valid", {31'h0, instr_valid}, 32'h0);
    endtask

    initial begin
        logic [31:0] pc_m;

        rst_n      = 1'b0;
        stall      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        NextPC     = 32'h0;

        vecs[0] = '{rdata: 32'h0800_0C01, lat: 0, stall_n: 0, next_pc: 32'h0000_3004};
        vecs[1] = '{rdata: 32'h8C22_0004, lat: 2, stall_n: 5, next_pc: 32'h0000_3008};
        vecs[2] = '{rdata: 32'hFFFF_FFFF, lat: 3, stall_n: 1, next_pc: 32'h0000_0000};
        vecs[3] = '{rdata: 32'h1234_5678, lat: 1, stall_n: 0, next_pc: 32'hFFFF_FFFC};

        // Table-driven fetch loop; lat=3 puts the ack on the terminal cycle.
        do_reset("rst0");
        pc_m = C_RST_PC;
        for (int v = 0; v < 4; v++) begin
            fetch(vecs[v].rdata, vecs[v].lat, pc_m);
            advance(vecs[v].stall_n, vecs[v].next_pc, pc_m, vecs[v].rdata);
            pc_m = vecs[v].next_pc;
        end

        // Misaligned NextPC, masked by stall first, then faulting.
        do_reset("rst1");
        fetch(32'h0800_0C01, 0, C_RST_PC);
        advance(0, 32'h0000_3004, C_RST_PC, 32'h0800_0C01);
        fetch(32'hAABB_CCDD, 0, 32'h0000_3004);
        for (int i = 0; i < 3; i++) begin
            stall  = 1'b1;
            NextPC = 32'h0000_3006;
            step();
            check("mis_stall_fault", {31'h0, fault}, 32'h0);
            check("mis_stall_valid", {31'h0, instr_valid}, 32'h1);
        end
        stall = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("mis_fault", {31'h0, fault}, 32'h1);
            check("mis_code", {30'h0, fault_code}, 32'h1);
            check("mis_pc", PC, 32'h0000_3004);
            check("mis_req", {31'h0, imem_req}, 32'h0);
            check("mis_valid", {31'h0, instr_valid}, 32'h0);
            check("mis_instr", Instr, 32'hAABB_CCDD);
            NextPC     = 32'h0000_3010;
            imem_ack   = 1'b1;
            imem_rdata = 32'h5555_5555;
            step();
            imem_ack = 1'b0;
        end

        // Ack timeout: fault after the 4th unanswered REQ cycle, later ack ignored.
        do_reset("rst2");
        for (int i = 1; i <= C_TIMEOUT; i++) begin
            step();
            if (i < C_TIMEOUT) begin
                check("to_wait_fault", {31'h0, fault}, 32'h0);
                check("to_wait_req", {31'h0, imem_req}, 32'h1);
            end else begin
                check("to_fault", {31'h0, fault}, 32'h1);
                check("to_code", {30'h0, fault_code}, 32'h2);
                check("to_req", {31'h0, imem_req}, 32'h0);
            end
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h7777_7777;
        step();
        imem_ack = 1'b0;
        check("to_late_instr", Instr, 32'h0);
        check("to_late_valid", {31'h0, instr_valid}, 32'h0);
        check("to_sticky", {31'h0, fault}, 32'h1);

        // Reset mid-request with an ack landing during reset.
        do_reset("rst3");
        step();
        rst_n = 1'b0;
        step();
        check("mid_req_drop", {31'h0, imem_req}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h6666_6666;
        step();
        imem_ack = 1'b0;
        check_reset_state("mid_rst");
        rst_n = 1'b1;
        step();
        check("mid_restart_req", {31'h0, imem_req}, 32'h1);
        check("mid_restart_addr", imem_addr, C_RST_PC);
        fetch(32'h0C00_1234, 1, C_RST_PC);

        check("sb_empty", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire
